// File: rtl/my_pecell_rst_seq.sv
// PE cell reset sequencer: synchronizes reset release, holds the PE in reset, runs init, then enables it.
// Optional RUN-cycle counter is built only when PECELL_CYCLE_CNT_EN is defined.
module my_pecell_rst_seq #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned HOLD_CYCLES  = 16,
  parameter int unsigned INIT_TIMEOUT = 1024,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             soft_rst_req,
  input  logic             init_done,
  output logic             pe_rst_n,
  output logic             pe_init_req,
  output logic             pe_en,
  output logic             seq_busy,
  output logic             init_err,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int unsigned TW = 16;

  typedef enum logic [2:0] {
    ST_RST,
    ST_HOLD,
    ST_INIT,
    ST_RUN,
    ST_ERR
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rst_sync;
  logic [TW-1:0]          hold_q, hold_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   err_d;
  logic                   pe_rst_n_d, pe_init_req_d, pe_en_d, seq_busy_d;

  // Reset-release synchronizer: shifts in ones after rst_n deasserts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  assign rst_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RST;
      hold_q      <= '0;
      tmo_q       <= '0;
      init_err    <= 1'b0;
      pe_rst_n    <= 1'b0;
      pe_init_req <= 1'b0;
      pe_en       <= 1'b0;
      seq_busy    <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      tmo_q       <= tmo_d;
      init_err    <= err_d;
      pe_rst_n    <= pe_rst_n_d;
      pe_init_req <= pe_init_req_d;
      pe_en       <= pe_en_d;
      seq_busy    <= seq_busy_d;
    end
  end

  // Next state plus outputs decoded from the next state so they move with the state.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    tmo_d   = tmo_q;
    err_d   = init_err;
    case (state_q)
      ST_RST: begin
        if (rst_sync) begin
          state_d = ST_HOLD;
          hold_d  = '0;
        end
      end
      ST_HOLD: begin
        if (hold_q == TW'(HOLD_CYCLES - 1)) begin
          state_d = ST_INIT;
          tmo_d   = '0;
        end else begin
          hold_d = hold_q + TW'(1);
        end
      end
      ST_INIT: begin
        if (init_done) begin
          state_d = ST_RUN;
        end else if (tmo_q == TW'(INIT_TIMEOUT - 1)) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_RUN: begin
        if (soft_rst_req) begin
          state_d = ST_HOLD;
          hold_d  = '0;
        end
      end
      ST_ERR: begin
        if (soft_rst_req) begin
          state_d = ST_HOLD;
          hold_d  = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = ST_RST;
    endcase

    pe_rst_n_d    = (state_d != ST_RST) && (state_d != ST_HOLD);
    pe_init_req_d = (state_d == ST_INIT);
    pe_en_d       = (state_d == ST_RUN);
    seq_busy_d    = (state_d != ST_RUN) && (state_d != ST_ERR);
  end

`ifdef PECELL_CYCLE_CNT_EN
  // Counts cycles spent in RUN; wraps naturally and clears only on rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cycle_cnt <= '0;
    else if (state_q == ST_RUN) cycle_cnt <= cycle_cnt + CNT_W'(1);
  end
`else
  assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_my_pecell_rst_seq.sv
// Randomized self-checking bench for my_pecell_rst_seq against a phase/countdown reference model.
module tb_my_pecell_rst_seq;

  localparam int SYNC = 2;
  localparam int HOLD = 16;
  localparam int TMO  = 1024;
  localparam int CW   = 32;

  localparam int P_RST  = 0;
  localparam int P_HOLD = 1;
  localparam int P_INIT = 2;
  localparam int P_RUN  = 3;
  localparam int P_ERR  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          soft_rst_req = 1'b0;
  logic          init_done = 1'b0;
  logic          pe_rst_n, pe_init_req, pe_en, seq_busy, init_err;
  logic [CW-1:0] cycle_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model
  int            m_ph;
  int            m_rel;
  int            m_left;
  int            m_wait;
  logic          m_err;
  logic [CW-1:0] m_cnt;

  my_pecell_rst_seq #(
    .SYNC_STAGES (SYNC),
    .HOLD_CYCLES (HOLD),
    .INIT_TIMEOUT(TMO),
    .CNT_W       (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .soft_rst_req(soft_rst_req),
    .init_done   (init_done),
    .pe_rst_n    (pe_rst_n),
    .pe_init_req (pe_init_req),
    .pe_en       (pe_en),
    .seq_busy    (seq_busy),
    .init_err    (init_err),
    .cycle_cnt   (cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_ph   = P_RST;
    m_rel  = 0;
    m_left = 0;
    m_wait = 0;
    m_err  = 1'b0;
    m_cnt  = '0;
  endtask

  // One rising edge of the reference: release delay, hold countdown, init wait, run/err handling.
  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
      return;
    end
    case (m_ph)
      P_RST: begin
        if (m_rel >= SYNC) begin
          m_ph   = P_HOLD;
          m_left = HOLD;
        end
        m_rel = m_rel + 1;
      end
      P_HOLD: begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_ph   = P_INIT;
          m_wait = 0;
        end
      end
      P_INIT: begin
        if (init_done) m_ph = P_RUN;
        else begin
          m_wait = m_wait + 1;
          if (m_wait == TMO) begin
            m_ph  = P_ERR;
            m_err = 1'b1;
          end
        end
      end
      P_RUN: begin
        m_cnt = m_cnt + 1'b1;
        if (soft_rst_req) begin
          m_ph   = P_HOLD;
          m_left = HOLD;
        end
      end
      default: begin
        if (soft_rst_req) begin
          m_ph   = P_HOLD;
          m_left = HOLD;
          m_err  = 1'b0;
        end
      end
    endcase
  endtask

  function automatic logic [CW+4:0] exp_vec();
    logic [CW-1:0] c;
`ifdef PECELL_CYCLE_CNT_EN
    c = m_cnt;
`else
    c = '0;
`endif
    return {(m_ph != P_RST && m_ph != P_HOLD), (m_ph == P_INIT), (m_ph == P_RUN),
            (m_ph != P_RUN && m_ph != P_ERR), m_err, c};
  endfunction

  function automatic logic [CW+4:0] got_vec();
    return {pe_rst_n, pe_init_req, pe_en, seq_busy, init_err, cycle_cnt};
  endfunction

  function automatic logic [CW-1:0] exp_run_cnt(input logic [CW-1:0] v);
`ifdef PECELL_CYCLE_CNT_EN
    return v;
`else
    return '0 & v;
`endif
  endfunction

  // Advance one clock: model sees the inputs at the edge, outputs are sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [CW+4:0] rst_vec;
    rst_vec = {5'b00010, {CW{1'b0}}};
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++;
      if (got_vec() !== rst_vec) begin
        n_bad++;
        $display("FAIL reset_values cycle %0d: got %h want %h", i, got_vec(), rst_vec);
      end
    end
  endtask

  task automatic test_release_latency();
    int edge_n;
    edge_n = -1;
    rst_n = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      step();
      n_cmp++;
      if (got_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL release_model edge %0d: got %h want %h", n, got_vec(), exp_vec());
      end
      if (pe_rst_n === 1'b1) begin
        edge_n = n;
        break;
      end
    end
    n_cmp++;
    if (edge_n !== SYNC + HOLD + 1) begin
      n_bad++;
      $display("FAIL release_latency: got edge %0d want %0d", edge_n, SYNC + HOLD + 1);
    end
    n_cmp++;
    if (pe_init_req !== 1'b1) begin
      n_bad++;
      $display("FAIL init_req_with_release: got %b want 1", pe_init_req);
    end
  endtask

  task automatic test_timeout();
    int k_err;
    k_err = -1;
    init_done = 1'b0;
    for (int k = 1; k <= TMO + 5; k++) begin
      step();
      n_cmp++;
      if (got_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL timeout_model init edge %0d: got %h want %h", k, got_vec(), exp_vec());
      end
      if (init_err === 1'b1) begin
        k_err = k;
        break;
      end
    end
    n_cmp++;
    if (k_err !== TMO) begin
      n_bad++;
      $display("FAIL timeout_edge: got %0d want %0d", k_err, TMO);
    end
    n_cmp++;
    if ({pe_init_req, seq_busy, pe_rst_n} !== 3'b001) begin
      n_bad++;
      $display("FAIL err_outputs: got init_req/busy/rst_n %b want 001",
               {pe_init_req, seq_busy, pe_rst_n});
    end
  endtask

  task automatic test_soft_err();
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (init_err !== 1'b1) begin
        n_bad++;
        $display("FAIL err_sticky cycle %0d: got %b want 1", i, init_err);
      end
    end
    soft_rst_req = 1'b1;
    step();
    soft_rst_req = 1'b0;
    n_cmp++;
    if ({init_err, pe_rst_n, seq_busy} !== 3'b001) begin
      n_bad++;
      $display("FAIL err_soft_exit: got err/rst_n/busy %b want 001", {init_err, pe_rst_n, seq_busy});
    end
    for (int i = 1; i <= HOLD; i++) begin
      step();
      n_cmp++;
      if (got_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL err_hold_model cycle %0d: got %h want %h", i, got_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (pe_init_req !== 1'b1) begin
      n_bad++;
      $display("FAIL err_hold_len: got init_req %b want 1", pe_init_req);
    end
  endtask

  task automatic test_init_done_5th();
    for (int i = 1; i <= 4; i++) step();
    init_done = 1'b1;
    step();
    init_done = 1'b0;
    n_cmp++;
    if ({pe_en, seq_busy, pe_init_req} !== 3'b100) begin
      n_bad++;
      $display("FAIL run_entry: got en/busy/init_req %b want 100", {pe_en, seq_busy, pe_init_req});
    end
    for (int i = 1; i <= 100; i++) begin
      init_done = 1'($urandom_range(0, 1));
      step();
      n_cmp++;
      if (got_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL run_model cycle %0d: got %h want %h", i, got_vec(), exp_vec());
      end
    end
    init_done = 1'b0;
    n_cmp++;
    if (cycle_cnt !== exp_run_cnt(CW'(100))) begin
      n_bad++;
      $display("FAIL cycle_cnt_100: got %0d want %0d", cycle_cnt, exp_run_cnt(CW'(100)));
    end
  endtask

  task automatic test_soft_run();
    logic [CW-1:0] held;
    soft_rst_req = 1'b1;
    step();
    soft_rst_req = 1'b0;
    held = cycle_cnt;
    n_cmp++;
    if (held !== exp_run_cnt(CW'(101))) begin
      n_bad++;
      $display("FAIL soft_run_cnt: got %0d want %0d", held, exp_run_cnt(CW'(101)));
    end
    for (int i = 1; i <= HOLD; i++) begin
      n_cmp++;
      if ({pe_rst_n, pe_en, pe_init_req} !== 3'b000 || cycle_cnt !== held) begin
        n_bad++;
        $display("FAIL soft_run_hold cycle %0d: got rst_n/en/init_req %b cnt %0d want 000 cnt %0d",
                 i, {pe_rst_n, pe_en, pe_init_req}, cycle_cnt, held);
      end
      soft_rst_req = 1'($urandom_range(0, 1));
      step();
    end
    soft_rst_req = 1'b0;
    n_cmp++;
    if ({pe_rst_n, pe_init_req, cycle_cnt} !== {2'b11, held}) begin
      n_bad++;
      $display("FAIL soft_run_init: got rst_n/init_req %b cnt %0d want 11 cnt %0d",
               {pe_rst_n, pe_init_req}, cycle_cnt, held);
    end
  endtask

  task automatic async_pulse(input string tag);
    logic [CW+4:0] rst_vec;
    rst_vec = {5'b00010, {CW{1'b0}}};
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (got_vec() !== rst_vec) begin
      n_bad++;
      $display("FAIL async_%s: got %h want %h", tag, got_vec(), rst_vec);
    end
    @(negedge clk);
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_async_mid();
    for (int i = 0; i < 7; i++) step();
    async_pulse("init");
    for (int i = 0; i < SYNC + 6; i++) step();
    n_cmp++;
    if (got_vec() !== exp_vec() || m_ph != P_HOLD) begin
      n_bad++;
      $display("FAIL pre_hold_pulse: got %h want %h", got_vec(), exp_vec());
    end
    async_pulse("hold");
  endtask

  task automatic test_random();
    int rst_left;
    int slow;
    rst_left = 0;
    for (int i = 0; i < 6000; i++) begin
      slow = (i / 1500) % 2;
      soft_rst_req = ($urandom_range(0, 24) == 0);
      init_done    = slow ? ($urandom_range(0, 1999) == 0) : ($urandom_range(0, 99) == 0);
      if (rst_left > 0) begin
        rst_left--;
        if (rst_left == 0) rst_n = 1'b1;
      end else if ($urandom_range(0, 799) == 0) begin
        rst_n = 1'b0;
        rst_left = $urandom_range(1, 4);
      end
      step();
      n_cmp++;
      if (got_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL random cycle %0d: got %h want %h", i, got_vec(), exp_vec());
      end
    end
    rst_n = 1'b1;
    soft_rst_req = 1'b0;
    init_done = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_release_latency();
    test_timeout();
    test_soft_err();
    test_init_done_5th();
    test_soft_run();
    test_async_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/my_pecell_rst_seq.md
MY_PECELL_RST_SEQ -- requirements
Module: my_pecell_rst_seq

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of flops in the reset-release synchronizer, legal range 2..4.
REQ-002 Parameter HOLD_CYCLES, default 16: cycles pe_rst_n is held low after synchronized release, legal range 1..65535.
REQ-003 Parameter INIT_TIMEOUT, default 1024: maximum cycles allowed in INIT waiting for init_done, legal range 1..65535.
REQ-004 Parameter CNT_W, default 32: width of cycle_cnt.
REQ-005 clk  input  1  free-running clock; all logic is on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 soft_rst_req  input  1  single-cycle request to re-run the hold/init sequence.
REQ-008 init_done  input  1  PE cell reports initialisation complete; level.
REQ-009 pe_rst_n  output  1  synchronized reset to the PE cell; asserts asynchronously and deasserts synchronously.
REQ-010 pe_init_req  output  1  init request to the PE cell; level.
REQ-011 pe_en  output  1  PE cell operate enable.
REQ-012 seq_busy  output  1  high in every state except RUN and ERR.
REQ-013 init_err  output  1  sticky init-timeout flag.
REQ-014 cycle_cnt  output  CNT_W  count of cycles spent in RUN.

Function
REQ-015 rst_n low SHALL clear the SYNC_STAGES-deep chain; the chain loads 1 at its input, and its last stage is rst_sync.
REQ-016 FSM states SHALL be RST, HOLD, INIT, RUN and ERR, with state encoding internal.
REQ-017 RST: while rst_sync is 0 the FSM SHALL remain in RST; the first cycle rst_sync reads 1, it SHALL go to HOLD and load the hold counter with 0.
REQ-018 HOLD: the hold counter SHALL increment each cycle; when it equals HOLD_CYCLES-1, the FSM SHALL go to INIT.
REQ-019 INIT: the FSM SHALL go to RUN on the first cycle init_done is 1; if the timeout counter reaches INIT_TIMEOUT-1 with init_done still 0, it SHALL go to ERR; if both occur in the same cycle, init_done SHALL win.
REQ-020 RUN: soft_rst_req SHALL send the FSM to HOLD with the hold counter cleared.
REQ-021 ERR: soft_rst_req SHALL clear init_err and send the FSM to HOLD; no other exit exists except rst_n.
REQ-022 soft_rst_req SHALL be ignored in RST, HOLD and INIT.
REQ-023 All outputs SHALL be registered, decoded from the next state, so they change on the same edge as the state.
REQ-024 pe_rst_n SHALL be 0 in RST and HOLD, and 1 otherwise.
REQ-025 pe_init_req SHALL be 1 only in INIT; pe_en SHALL be 1 only in RUN.
REQ-026 Latency: pe_rst_n SHALL rise exactly SYNC_STAGES+HOLD_CYCLES+1 rising edges after rst_n deasserts, counted from the first edge after release.
REQ-027 init_err SHALL set on entry to ERR and hold until soft_rst_req or rst_n.
REQ-028 cycle_cnt SHALL increment every cycle in RUN, wrap from all-ones to 0, hold its value outside RUN, and clear only on rst_n.
REQ-029 If rst_n asserts mid-sequence in any state, all outputs SHALL go to reset values immediately, without waiting for a clock edge.

Reset
REQ-030 Reset values SHALL be: pe_rst_n=0, pe_init_req=0, pe_en=0, seq_busy=1, init_err=0, cycle_cnt=0, FSM=RST, all counters 0.
REQ-031 Every flop in the block SHALL use asynchronous active-low rst_n; no flop is reset from soft_rst_req asynchronously.

Configuration
REQ-032 Macro PECELL_CYCLE_CNT_EN defined: the cycle counter SHALL be implemented as in REQ-028.
REQ-033 Macro PECELL_CYCLE_CNT_EN undefined: no counter flops SHALL be instantiated, and cycle_cnt SHALL be constant 0; all other behaviour is unchanged.

Verification
REQ-034 Defaults; rst_n low 10 cycles, then high; init_done=0 -> pe_rst_n rises on edge 19 after release; pe_init_req rises on the same edge.
REQ-035 Continue REQ-034 with init_done held 0 -> on edge 1024 in INIT: init_err=1, pe_init_req=0, seq_busy=0.
REQ-036 Drive init_done=1 on the 5th INIT cycle -> next edge: pe_en=1, seq_busy=0; after 100 RUN cycles, cycle_cnt=100.
REQ-037 In RUN, pulse soft_rst_req -> pe_rst_n=0 and pe_en=0 for 16 cycles, then INIT; cycle_cnt holds at its value (e.g. 100).
REQ-038 rst_n pulsed low mid-HOLD, and separately mid-INIT -> all outputs return to reset values before the next clock edge.
REQ-039 Build without PECELL_CYCLE_CNT_EN, run REQ-036 -> cycle_cnt=0 throughout; all other responses identical.
